// File: rtl/mining_pkg.sv
// Shared constants and FSM encoding for the mining pipeline target-check stage.
package mining_pkg;

    localparam int unsigned HASH_W  = 256;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned NONCE_W = 32;
    localparam int unsigned N_WORDS = HASH_W / WORD_W;

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StIssue = 3'd1;
    localparam state_t StWait  = 3'd2;
    localparam state_t StCmp   = 3'd3;
    localparam state_t StDone  = 3'd4;

endpackage

// File: rtl/hash_word_cmp.sv
// Combinational unsigned three-way compare of one hash slice against one target slice.
module hash_word_cmp #(
    parameter int unsigned WORD_W = mining_pkg::WORD_W
) (
    input  logic [WORD_W-1:0] hash_word,
    input  logic [WORD_W-1:0] target_word,
    output logic              lt,
    output logic              eq,
    output logic              gt
);

    assign lt = hash_word <  target_word;
    assign eq = hash_word == target_word;
    assign gt = hash_word >  target_word;

endmodule

// File: rtl/hash_target_check.sv
// Nonce sweep controller: requests a hash per nonce and checks it against the target
// one word per cycle, most significant word first, stopping at the first differing word.
module hash_target_check #(
    parameter int unsigned HASH_W  = mining_pkg::HASH_W,
    parameter int unsigned WORD_W  = mining_pkg::WORD_W,
    parameter int unsigned NONCE_W = mining_pkg::NONCE_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [HASH_W-1:0]  target,
    input  logic [NONCE_W-1:0] nonce_base,
    input  logic [NONCE_W-1:0] nonce_limit,
    input  logic               hash_valid,
    input  logic [HASH_W-1:0]  hash,
    output logic               nonce_req,
    output logic [NONCE_W-1:0] nonce_out,
    output logic               busy,
    output logic               found,
    output logic [NONCE_W-1:0] found_nonce,
    output logic [HASH_W-1:0]  found_hash,
    output logic               exhausted
);

    import mining_pkg::*;

    localparam int unsigned NumWords = HASH_W / WORD_W;
    localparam int unsigned IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1;

    state_t             state_q, state_d;
    logic [HASH_W-1:0]  target_q, target_d;
    logic [HASH_W-1:0]  hash_q, hash_d;
    logic [HASH_W-1:0]  found_hash_q, found_hash_d;
    logic [NONCE_W-1:0] nonce_cur_q, nonce_cur_d;
    logic [NONCE_W-1:0] nonce_limit_q, nonce_limit_d;
    logic [NONCE_W-1:0] found_nonce_q, found_nonce_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic               found_q, found_d;
    logic               exhausted_q, exhausted_d;
    logic               nonce_req_q;
    logic               busy_q;

    logic [WORD_W-1:0]  hash_word, target_word;
    logic               word_lt, word_eq, word_gt;

    always_comb begin
        hash_word   = '0;
        target_word = '0;
        for (int unsigned w = 0; w < NumWords; w++) begin
            if (idx_q == IdxW'(w)) begin
                hash_word   = hash_q[w*WORD_W +: WORD_W];
                target_word = target_q[w*WORD_W +: WORD_W];
            end
        end
    end

    hash_word_cmp #(
        .WORD_W (WORD_W)
    ) u_word_cmp (
        .hash_word   (hash_word),
        .target_word (target_word),
        .lt          (word_lt),
        .eq          (word_eq),
        .gt          (word_gt)
    );

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        hash_d        = hash_q;
        found_hash_d  = found_hash_q;
        nonce_cur_d   = nonce_cur_q;
        nonce_limit_d = nonce_limit_q;
        found_nonce_d = found_nonce_q;
        idx_d         = idx_q;
        found_d       = found_q;
        exhausted_d   = exhausted_q;

        // Abort outranks every same-cycle event; found_nonce/found_hash are kept.
        if (abort) begin
            state_d     = StIdle;
            found_d     = 1'b0;
            exhausted_d = 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        target_d      = target;
                        nonce_cur_d   = nonce_base;
                        nonce_limit_d = nonce_limit;
                        found_d       = 1'b0;
                        exhausted_d   = 1'b0;
                        state_d       = StIssue;
                    end
                end
                StIssue: state_d = StWait;
                StWait: begin
                    if (hash_valid) begin
                        hash_d  = hash;
                        idx_d   = IdxW'(NumWords - 1);
                        state_d = StCmp;
                    end
                end
                StCmp: begin
                    if (word_lt || (word_eq && idx_q == '0)) begin
                        found_nonce_d = nonce_cur_q;
                        found_hash_d  = hash_q;
                        found_d       = 1'b1;
                        state_d       = StDone;
                    end else if (word_gt) begin
                        if (nonce_cur_q == nonce_limit_q) begin
                            exhausted_d = 1'b1;
                            state_d     = StDone;
                        end else begin
                            nonce_cur_d = nonce_cur_q + 1'b1;
                            state_d     = StIssue;
                        end
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            target_q      <= '0;
            hash_q        <= '0;
            found_hash_q  <= '0;
            nonce_cur_q   <= '0;
            nonce_limit_q <= '0;
            found_nonce_q <= '0;
            idx_q         <= '0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            nonce_req_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            hash_q        <= hash_d;
            found_hash_q  <= found_hash_d;
            nonce_cur_q   <= nonce_cur_d;
            nonce_limit_q <= nonce_limit_d;
            found_nonce_q <= found_nonce_d;
            idx_q         <= idx_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
            // Status flags are registered from the next state so they line up with it.
            nonce_req_q   <= (state_d == StIssue);
            busy_q        <= (state_d == StIssue) || (state_d == StWait) || (state_d == StCmp);
        end
    end

    assign nonce_req   = nonce_req_q;
    assign nonce_out   = nonce_cur_q;
    assign busy        = busy_q;
    assign found       = found_q;
    assign found_nonce = found_nonce_q;
    assign found_hash  = found_hash_q;
    assign exhausted   = exhausted_q;

endmodule

// File: tb/tb_hash_target_check.sv
// Randomized bench for hash_target_check: plays the upstream hasher and predicts each
// search outcome from plain wide-integer comparison of hash against target.
module tb_hash_target_check;

    localparam int unsigned HW     = 256;
    localparam int unsigned WW     = 32;
    localparam int unsigned NW     = 32;
    localparam int unsigned NWORDS = HW / WW;

    logic          clock = 1'b0;
    logic          reset, start, abort, hash_valid;
    logic [HW-1:0] target, hash;
    logic [NW-1:0] nonce_base, nonce_limit;
    logic          nonce_req, busy, found, exhausted;
    logic [NW-1:0] nonce_out, found_nonce;
    logic [HW-1:0] found_hash;

    int            n_compared   = 0;
    int            n_mismatched = 0;
    logic [NW-1:0] last_found_nonce = '0;
    logic [HW-1:0] last_found_hash  = '0;

    hash_target_check dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .target      (target),
        .nonce_base  (nonce_base),
        .nonce_limit (nonce_limit),
        .hash_valid  (hash_valid),
        .hash        (hash),
        .nonce_req   (nonce_req),
        .nonce_out   (nonce_out),
        .busy        (busy),
        .found       (found),
        .found_nonce (found_nonce),
        .found_hash  (found_hash),
        .exhausted   (exhausted)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [HW-1:0] rand_target();
        logic [HW-1:0] t;
        for (int w = 0; w < NWORDS; w++) t[w*WW +: WW] = $urandom;
        t[HW-1 -: WW] = $urandom_range(0, 32'h00FF_FFFF);
        return t;
    endfunction

    // Early-exit length: one cycle plus one per leading word that matches.
    function automatic int cmp_cycles(input logic [HW-1:0] h, input logic [HW-1:0] t);
        int n = 1;
        for (int w = NWORDS - 1; w > 0; w--) begin
            if (h[w*WW +: WW] != t[w*WW +: WW]) break;
            n++;
        end
        return n;
    endfunction

    // 1: zero, 2: all ones, 3: equal to target, 4: target+1, other: random mix.
    function automatic logic [HW-1:0] gen_hash(input logic [HW-1:0] t, input int mode);
        logic [HW-1:0] h;
        int            r;
        case (mode)
            1: h = '0;
            2: h = '1;
            3: h = t;
            4: h = t + 1;
            default: begin
                r = $urandom_range(0, 9);
                h = t;
                if (r < 5) begin
                    for (int w = 0; w < NWORDS; w++) h[w*WW +: WW] = $urandom;
                end else if (r < 7) begin
                    int j = $urandom_range(0, NWORDS - 1);
                    h[j*WW +: WW] = h[j*WW +: WW] ^ (32'h1 << $urandom_range(0, 31));
                end else if (r == 8) begin
                    h = t - 1;
                end else if (r == 9) begin
                    h = '1;
                end
            end
        endcase
        return h;
    endfunction

    task automatic run_search(input logic [NW-1:0] base, input logic [NW-1:0] limit,
                              input logic [HW-1:0] tgt, input int mode);
        logic [NW-1:0] exp_nonce;
        logic [HW-1:0] h;
        int            k, lat, guard;
        bit            done;
        target      = tgt;
        nonce_base  = base;
        nonce_limit = limit;
        start       = 1'b1;
        tick();
        start     = 1'b0;
        exp_nonce = base;
        done      = 1'b0;
        guard     = 0;
        while (!done && guard < 64) begin
            guard++;
            check("nonce_req", nonce_req, 1);
            check("nonce_out", nonce_out, exp_nonce);
            check("busy_issue", busy, 1);
            lat = $urandom_range(1, 3);
            for (int c = 0; c < lat; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    // Start while busy must be ignored; scramble the latched inputs too.
                    start       = 1'b1;
                    nonce_base  = $urandom;
                    nonce_limit = $urandom;
                    target      = '0;
                end
                tick();
                start = 1'b0;
                check("wait_state", {nonce_req, busy, found, exhausted}, 4'b0100);
            end
            h          = gen_hash(tgt, mode);
            hash       = h;
            hash_valid = 1'b1;
            tick();
            hash_valid = 1'b0;
            hash       = {8{$urandom}};
            k          = cmp_cycles(h, tgt);
            for (int c = 1; c < k; c++) begin
                tick();
                check("cmp_state", {found, exhausted, nonce_req, busy}, 4'b0001);
            end
            tick();
            if (h <= tgt) begin
                check("found", found, 1);
                check("exhausted_on_hit", exhausted, 0);
                check("found_nonce", found_nonce, exp_nonce);
                check("found_hash", found_hash, h);
                check("busy_done", busy, 0);
                last_found_nonce = exp_nonce;
                last_found_hash  = h;
                done = 1'b1;
            end else if (exp_nonce == limit) begin
                check("exhausted", exhausted, 1);
                check("found_on_exhaust", found, 0);
                check("busy_done", busy, 0);
                done = 1'b1;
            end else begin
                exp_nonce = exp_nonce + 1'b1;
            end
        end
        check("sweep_bound", done, 1);
        tick();
        check("done_hold", {nonce_req, busy}, 2'b00);
        check("done_nonce_hold", nonce_out, exp_nonce);
        check("done_found_nonce_hold", found_nonce, last_found_nonce);
    endtask

    initial begin
        logic [HW-1:0] tgt;
        logic [NW-1:0] base;
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        hash_valid  = 1'b0;
        target      = '0;
        hash        = '0;
        nonce_base  = '0;
        nonce_limit = '0;
        repeat (2) tick();
        reset = 1'b0;
        check("rst_flags", {nonce_req, busy, found, exhausted}, 4'b0000);
        check("rst_nonce_out", nonce_out, 0);
        check("rst_found_nonce", found_nonce, 0);
        check("rst_found_hash", found_hash, 0);

        // Directed corner cases.
        tgt = rand_target();
        tgt[HW-1 -: WW] = 32'h0000_FFFF;
        run_search(32'd5, 32'd7, tgt, 1);
        run_search(32'd0, 32'd2, tgt, 2);
        tgt = rand_target();
        tgt[WW-1:0] = $urandom_range(0, 32'hFFFF_FFFE);
        run_search(32'd10, 32'd10, tgt, 3);
        run_search(32'd10, 32'd10, tgt, 4);
        run_search(32'hFFFF_FFFE, 32'h0000_0001, tgt, 2);

        // Abort coincident with hash_valid in WAIT.
        target     = tgt;
        nonce_base = 32'd100;
        nonce_limit = 32'd200;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        hash       = '0;
        hash_valid = 1'b1;
        abort      = 1'b1;
        tick();
        hash_valid = 1'b0;
        abort      = 1'b0;
        check("abort_flags", {nonce_req, busy, found, exhausted}, 4'b0000);
        check("abort_found_nonce", found_nonce, last_found_nonce);
        check("abort_found_hash", found_hash, last_found_hash);
        tick();
        check("abort_idle", {nonce_req, busy, found}, 3'b000);

        // Abort outranks a same-cycle start; abort from DONE clears found.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_start", {nonce_req, busy}, 2'b00);
        run_search(32'd40, 32'd40, tgt, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_done_found", found, 0);
        check("abort_done_keep", found_nonce, last_found_nonce);

        // Randomized sweeps, some straddling the nonce wrap point.
        for (int i = 0; i < 24; i++) begin
            tgt  = rand_target();
            base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3) : $urandom;
            run_search(base, base + $urandom_range(0, 5), tgt, 0);
        end

        // Reset in the middle of an 8-word compare.
        tgt        = rand_target();
        target     = tgt;
        nonce_base = 32'd9;
        nonce_limit = 32'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        hash       = tgt;
        hash_valid = 1'b1;
        tick();
        hash_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_flags", {nonce_req, busy, found, exhausted}, 4'b0000);
        check("midrst_nonce_out", nonce_out, 0);
        check("midrst_found_nonce", found_nonce, 0);
        check("midrst_found_hash", found_hash, 0);
        hash       = '0;
        hash_valid = 1'b1;
        tick();
        hash_valid = 1'b0;
        repeat (2) tick();
        check("late_valid_ignored", {nonce_req, busy, found, exhausted}, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/hash_target_check.md
# hash_target_check

Downstream stage of the SHA-256 compression block in the mining pipeline: consumes each 256-bit `HASH` it produces and decides whether it meets the difficulty target. Owns the nonce sweep. Issues a request for each nonce, waits for the hash, and compares it against the target 32 bits per cycle, MSW first, with early exit. Reports the first winning nonce, or exhaustion of the nonce range.

## Interface
- `HASH_W`, 256, hash and target width
- `WORD_W`, 32, compare slice per cycle; `HASH_W` must be a multiple of it
- `NONCE_W`, 32, nonce width
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  pulse; begins a search; ignored unless in IDLE or DONE
- `abort`  in  1  returns to IDLE on the next edge from any state
- `target`  in  HASH_W  difficulty target, latched on accepted `start`
- `nonce_base`  in  NONCE_W  first nonce, latched on `start`
- `nonce_limit`  in  NONCE_W  last nonce (inclusive), latched on `start`
- `hash_valid`  in  1  one-cycle strobe from compression stage
- `hash`  in  HASH_W  result for the last requested nonce; bit HASH_W-1 is the MSB
- `nonce_req`  out  1  one-cycle pulse; upstream must hash `nonce_out`
- `nonce_out`  out  NONCE_W  nonce currently under test
- `busy`  out  1  high in ISSUE, WAIT, CMP
- `found`  out  1  level; winning nonce held
- `found_nonce`  out  NONCE_W  winning nonce
- `found_hash`  out  HASH_W  winning hash
- `exhausted`  out  1  level; range ended with no hit

## Operation
- Hit condition: `hash <= target`, unsigned HASH_W-bit compare.
- States: IDLE, ISSUE, WAIT, CMP, DONE.
- IDLE: on `start`, latch target, base, and limit. Set `nonce_cur` to `nonce_base`, clear `found` and `exhausted`, then go to ISSUE.
- ISSUE: drive `nonce_req`=1 for exactly one cycle, then go to WAIT.
- WAIT: on `hash_valid`, latch `hash`, set word index `idx` to HASH_W/WORD_W-1, then go to CMP. `hash_valid` outside WAIT is ignored.
- CMP: each cycle compare slice `idx` of the hash against the same slice of the target.
  - Less: hit.
  - Greater: miss.
  - Equal and `idx`>0: decrement `idx` and stay in CMP.
  - Equal and `idx`=0: hit, because the values are equal.
- Hit: latch `found_nonce` and `found_hash`, set `found`=1, go to DONE.
- Miss and `nonce_cur` equals `nonce_limit`: set `exhausted`=1, go to DONE.
- Miss otherwise: `nonce_cur` is incremented mod 2^NONCE_W (so 0xFFFFFFFF becomes 0), go to ISSUE.
- `nonce_base` > `nonce_limit` is legal; the sweep wraps through 0.
- DONE: hold all results. `start` restarts as from IDLE.
- `abort` has priority over all events, including a same-cycle `start`, `hash_valid`, or compare decision. It clears `found`, `exhausted`, and `nonce_req`; `found_nonce` and `found_hash` keep their values.
- `start` while `busy` is ignored.

## Timing
- Reset values: state IDLE. `nonce_req`, `busy`, `found`, and `exhausted` are 0. `nonce_out`, `found_nonce`, and `found_hash` are all-zero.
- `start` sampled at edge N: `nonce_req`=1 and `nonce_out`=`nonce_base` during cycle N..N+1.
- `hash_valid` sampled at edge M: the compare occupies 1 to HASH_W/WORD_W cycles (8 by default). The decision is taken at edge M+k. Outputs of that decision (`found` or `exhausted`, or the next `nonce_req` pulse) are visible from edge M+k.
- Per-nonce overhead excluding upstream hash latency: 1 (ISSUE) + 1..8 (CMP) cycles.
- `nonce_out` is stable from ISSUE until the next ISSUE, or is held in DONE.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `mining_pkg`:
  - state enum (IDLE=0, ISSUE=1, WAIT=2, CMP=3, DONE=4)
  - `HASH_W`, `WORD_W`, `NONCE_W` defaults
  - derived `N_WORDS` = HASH_W/WORD_W
- Sub-module `hash_word_cmp`: combinational WORD_W-bit unsigned three-way compare with outputs `lt`, `eq`, `gt`. Instantiated once; slice selected by `idx`.
- Top holds the FSM, nonce counter, `idx` counter, and latched target, hash and results.

## Test plan
- Reset mid-CMP → next cycle state IDLE, all outputs at reset values, late `hash_valid` ignored.
- `nonce_base`=5, `nonce_limit`=7, hash MSW 0x00000000, target MSW 0x0000FFFF → `found`=1 and `found_nonce`=5 after 1 CMP cycle; exactly one `nonce_req`.
- `nonce_base`=0, `nonce_limit`=2, every hash MSW 0xFFFFFFFF, target MSW 0x0000FFFF → three `nonce_req` pulses with `nonce_out`=0,1,2, then `exhausted`=1, `found`=0.
- hash equal to target in all 8 words → 8 CMP cycles, then `found`=1 (equality is a hit). The same hash with LSW target−1 → miss after 8 cycles.
- `nonce_base`=0xFFFFFFFE, `nonce_limit`=0x00000001, all misses → `nonce_out` sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1, then `exhausted`.
- `abort` in the same cycle as `hash_valid` in WAIT → IDLE next cycle, `busy`=0, no `found`. `start` while `busy` → ignored, sweep continues unchanged.
